// File: rtl/reg_read_stage.sv
// Register-read stage: physical register file with writeback bypass, a registered
// operand packet with valid/ready toward execute, and a one-entry skid buffer.
module reg_read_stage_rdport #(
  parameter int XLEN   = 32,
  parameter int PREG_W = 6
) (
  input  logic [PREG_W-1:0] src,
  input  logic [XLEN-1:0]   prf_data,
  input  logic              wb_valid,
  input  logic [PREG_W-1:0] wb_preg,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   val
);
  always_comb begin
    if (src == '0)                          val = '0;
    else if (wb_valid && (wb_preg == src))  val = wb_data;
    else                                    val = prf_data;
  end
endmodule

module reg_read_stage #(
  parameter int  NUM_PREGS = 64,
  parameter int  XLEN      = 32,
  localparam int PREG_W    = $clog2(NUM_PREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fire_valid,
  output logic              fire_ready,
  input  logic [PREG_W-1:0] fire_dst_preg,
  input  logic [PREG_W-1:0] fire_src1_preg,
  input  logic [PREG_W-1:0] fire_src2_preg,
  input  logic [XLEN-1:0]   fire_pc,
  input  logic [XLEN-1:0]   fire_imm,
  input  logic              wb_valid,
  input  logic [PREG_W-1:0] wb_preg,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [PREG_W-1:0] ex_dst_preg,
  output logic [PREG_W-1:0] ex_src1_preg,
  output logic [PREG_W-1:0] ex_src2_preg,
  output logic [XLEN-1:0]   ex_src1_val,
  output logic [XLEN-1:0]   ex_src2_val,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm
);
  typedef struct packed {
    logic [PREG_W-1:0]          dst;
    logic [1:0][PREG_W-1:0]     src;
    logic [1:0][XLEN-1:0]       val;
    logic [XLEN-1:0]            pc;
    logic [XLEN-1:0]            imm;
  } pkt_t;

  logic [NUM_PREGS-1:0][XLEN-1:0] prf;
  logic [1:0][PREG_W-1:0]         rd_src;
  logic [1:0][XLEN-1:0]           rd_val;

  logic out_vld, out_vld_n, skid_vld, skid_vld_n;
  pkt_t out_pkt, out_pkt_n, skid_pkt, skid_pkt_n, fire_pkt;
  logic out_free, accept;

  assign rd_src = {fire_src2_preg, fire_src1_preg};

  for (genvar g = 0; g < 2; g++) begin : g_rd
    reg_read_stage_rdport #(.XLEN(XLEN), .PREG_W(PREG_W)) u_rd (
      .src      (rd_src[g]),
      .prf_data (prf[rd_src[g]]),
      .wb_valid (wb_valid),
      .wb_preg  (wb_preg),
      .wb_data  (wb_data),
      .val      (rd_val[g])
    );
  end

  // Held operands pick up a writeback to their source at the edge.
  function automatic pkt_t snoop(pkt_t p, logic wv, logic [PREG_W-1:0] wp, logic [XLEN-1:0] wd);
    pkt_t r;
    r = p;
    for (int i = 0; i < 2; i++)
      if (wv && (wp != '0) && (p.src[i] == wp)) r.val[i] = wd;
    return r;
  endfunction

  assign fire_pkt = '{dst: fire_dst_preg, src: rd_src, val: rd_val, pc: fire_pc, imm: fire_imm};
  assign out_free = !out_vld || ex_ready;
  assign accept   = fire_valid && !skid_vld && !flush;

  always_comb begin
    out_vld_n  = out_vld;
    skid_vld_n = skid_vld;
    out_pkt_n  = snoop(out_pkt,  wb_valid, wb_preg, wb_data);
    skid_pkt_n = snoop(skid_pkt, wb_valid, wb_preg, wb_data);
    if (flush) begin
      out_vld_n  = 1'b0;
      skid_vld_n = 1'b0;
    end else if (out_free) begin
      if (skid_vld) begin
        out_vld_n  = 1'b1;
        out_pkt_n  = snoop(skid_pkt, wb_valid, wb_preg, wb_data);
        skid_vld_n = 1'b0;
      end else begin
        out_vld_n = accept;
        if (accept) out_pkt_n = fire_pkt;
      end
    end else if (accept) begin
      skid_vld_n = 1'b1;
      skid_pkt_n = fire_pkt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      out_pkt  <= '0;
      skid_pkt <= '0;
    end else begin
      out_vld  <= out_vld_n;
      skid_vld <= skid_vld_n;
      out_pkt  <= out_pkt_n;
      skid_pkt <= skid_pkt_n;
    end
  end

  // PRF write is independent of flush; p0 is never written so it reads as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prf <= '0;
    else if (wb_valid && (wb_preg != '0)) prf[wb_preg] <= wb_data;
  end

  assign fire_ready   = !skid_vld;
  assign ex_valid     = out_vld;
  assign ex_dst_preg  = out_pkt.dst;
  assign ex_src1_preg = out_pkt.src[0];
  assign ex_src2_preg = out_pkt.src[1];
  assign ex_src1_val  = out_pkt.val[0];
  assign ex_src2_val  = out_pkt.val[1];
  assign ex_pc        = out_pkt.pc;
  assign ex_imm       = out_pkt.imm;
endmodule

// File: tb/tb_reg_read_stage.sv
// Bench for reg_read_stage: reference PRF plus in-flight queue scoreboard, a vector
// table, hand sequences for stall/snoop/flush, then random traffic with a mid-run reset.
module tb_reg_read_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        fire_valid = 0, fire_ready;
  logic [5:0]  fire_dst_preg = 0, fire_src1_preg = 0, fire_src2_preg = 0;
  logic [31:0] fire_pc = 0, fire_imm = 0;
  logic        wb_valid = 0;
  logic [5:0]  wb_preg = 0;
  logic [31:0] wb_data = 0;
  logic        flush = 0, ex_valid, ex_ready = 0;
  logic [5:0]  ex_dst_preg, ex_src1_preg, ex_src2_preg;
  logic [31:0] ex_src1_val, ex_src2_val, ex_pc, ex_imm;

  reg_read_stage #(.NUM_PREGS(64), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .fire_valid(fire_valid), .fire_ready(fire_ready),
    .fire_dst_preg(fire_dst_preg), .fire_src1_preg(fire_src1_preg),
    .fire_src2_preg(fire_src2_preg), .fire_pc(fire_pc), .fire_imm(fire_imm),
    .wb_valid(wb_valid), .wb_preg(wb_preg), .wb_data(wb_data), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_dst_preg(ex_dst_preg),
    .ex_src1_preg(ex_src1_preg), .ex_src2_preg(ex_src2_preg),
    .ex_src1_val(ex_src1_val), .ex_src2_val(ex_src2_val), .ex_pc(ex_pc), .ex_imm(ex_imm)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  dst, s1, s2;
    logic [31:0] v1, v2, pc, imm;
  } pkt_t;

  typedef struct {
    logic fv; logic [5:0] dst, s1, s2; logic [31:0] pc, imm;
    logic wbv; logic [5:0] wbp; logic [31:0] wbd;
    logic exr, fl, exp_v, exp_r;
  } vec_t;

  int          n_cmp = 0, n_err = 0;
  logic [31:0] mprf [64];
  pkt_t        q [$];
  vec_t        vecs [13];

  task automatic chk(string nm, logic [159:0] act, logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd(logic [5:0] s);
    if (s == 0) return 32'h0;
    if (wb_valid && wb_preg == s) return wb_data;
    return mprf[s];
  endfunction

  // Check current outputs against the model, then advance the model across one edge.
  task automatic cyc();
    pkt_t np, t;
    bit   pop, acc;
    chk("ex_valid", ex_valid, q.size() != 0);
    chk("fire_ready", fire_ready, q.size() < 2);
    if (q.size() != 0)
      chk("payload", {ex_dst_preg, ex_src1_preg, ex_src2_preg, ex_src1_val, ex_src2_val, ex_pc, ex_imm}, q[0]);
    pop = (q.size() != 0) && ex_ready;
    acc = fire_valid && (q.size() < 2) && !flush;
    np  = '{fire_dst_preg, fire_src1_preg, fire_src2_preg, rd(fire_src1_preg), rd(fire_src2_preg), fire_pc, fire_imm};
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      for (int i = 0; i < q.size(); i++) begin
        t = q[i];
        if (wb_valid && wb_preg != 0 && t.s1 == wb_preg) t.v1 = wb_data;
        if (wb_valid && wb_preg != 0 && t.s2 == wb_preg) t.v2 = wb_data;
        q[i] = t;
      end
      if (acc) q.push_back(np);
    end
    if (wb_valid && wb_preg != 0) mprf[wb_preg] = wb_data;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fire(logic v, logic [5:0] d, logic [5:0] a, logic [5:0] b, logic [31:0] pc);
    fire_valid = v; fire_dst_preg = d; fire_src1_preg = a; fire_src2_preg = b;
    fire_pc = pc; fire_imm = pc ^ 32'h5A5A;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mprf[i] = 0;
    //          fv dst s1 s2 pc        imm wbv wbp wbd            exr fl  v  r
    vecs[0]  = '{0, 0, 0, 0, 32'h000, 0, 1, 5, 32'hDEADBEEF, 1, 0, 0, 1};
    vecs[1]  = '{1, 10, 5, 0, 32'h100, 1, 0, 0, 32'h0,        1, 0, 1, 1};
    vecs[2]  = '{1, 11, 7, 5, 32'h104, 2, 1, 7, 32'h1234,     1, 0, 1, 1};
    vecs[3]  = '{1, 12, 7, 0, 32'h108, 3, 1, 0, 32'hFF,       1, 0, 1, 1};
    vecs[4]  = '{1, 13, 0, 0, 32'h10C, 4, 0, 0, 32'h0,        0, 0, 1, 0};
    vecs[5]  = '{1, 14, 0, 0, 32'h110, 5, 0, 0, 32'h0,        0, 0, 1, 0};
    vecs[6]  = '{0, 0, 0, 0, 32'h000, 0, 0, 0, 32'h0,         1, 0, 1, 1};
    vecs[7]  = '{0, 0, 0, 0, 32'h000, 0, 0, 0, 32'h0,         1, 0, 0, 1};
    vecs[8]  = '{1, 15, 5, 0, 32'h120, 6, 0, 0, 32'h0,        0, 0, 1, 1};
    vecs[9]  = '{1, 16, 7, 0, 32'h124, 7, 0, 0, 32'h0,        0, 0, 1, 0};
    vecs[10] = '{0, 0, 0, 0, 32'h000, 0, 1, 3, 32'h55,        0, 1, 0, 1};
    vecs[11] = '{1, 17, 3, 0, 32'h128, 8, 0, 0, 32'h0,        1, 0, 1, 1};
    vecs[12] = '{0, 0, 0, 0, 32'h000, 0, 0, 0, 32'h0,         1, 0, 0, 1};

    #1 rst = 1'b0;
    #1;
    chk("reset ex_valid", ex_valid, 0);
    chk("reset fire_ready", fire_ready, 1);
    chk("reset payload", {ex_dst_preg, ex_src1_preg, ex_src2_preg, ex_src1_val, ex_src2_val, ex_pc, ex_imm}, 0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      fire(vecs[i].fv, vecs[i].dst, vecs[i].s1, vecs[i].s2, vecs[i].pc);
      fire_imm = vecs[i].imm;
      wb_valid = vecs[i].wbv; wb_preg = vecs[i].wbp; wb_data = vecs[i].wbd;
      ex_ready = vecs[i].exr; flush = vecs[i].fl;
      cyc();
      chk($sformatf("vec%0d ex_valid", i), ex_valid, vecs[i].exp_v);
      chk($sformatf("vec%0d fire_ready", i), fire_ready, vecs[i].exp_r);
      if (i == 1) chk("basic src1", ex_src1_val, 32'hDEADBEEF);
      if (i == 2) chk("bypass src1", ex_src1_val, 32'h1234);
      if (i == 3) chk("p7 reread", ex_src1_val, 32'h1234);
      if (i == 11) chk("p3 after flush", ex_src1_val, 32'h55);
    end
    wb_valid = 0; flush = 0;

    // Backpressure: A in OUT, B in SKID, then drain in order.
    ex_ready = 0;
    fire(1, 20, 1, 2, 32'h1000); cyc();
    fire(1, 21, 2, 1, 32'h2000); cyc();
    fire(0, 0, 0, 0, 0);
    chk("bp fire_ready low", fire_ready, 0);
    chk("bp ex_pc A", ex_pc, 32'h1000);
    cyc();
    chk("bp ex_pc A held", ex_pc, 32'h1000);
    ex_ready = 1; cyc();
    chk("bp ex_pc B", ex_pc, 32'h2000);
    chk("bp fire_ready back", fire_ready, 1);
    cyc();

    // Snoop while stalled: A src2=9 in OUT, B src1=9 in SKID.
    ex_ready = 0;
    fire(1, 22, 0, 9, 32'h3000); cyc();
    fire(1, 23, 9, 0, 32'h4000); cyc();
    fire(0, 0, 0, 0, 0);
    wb_valid = 1; wb_preg = 9; wb_data = 32'hAA; cyc();
    wb_valid = 0;
    chk("snoop OUT src2", ex_src2_val, 32'hAA);
    ex_ready = 1; cyc();
    chk("snoop SKID src1", ex_src1_val, 32'hAA);
    chk("snoop SKID pc", ex_pc, 32'h4000);
    cyc();

    // Random traffic with a mid-cycle reset.
    for (int n = 0; n < 400; n++) begin
      fire($urandom_range(0, 9) < 7, 6'($urandom_range(1, 63)), 6'($urandom_range(0, 7)),
           6'($urandom_range(0, 7)), $urandom);
      wb_valid = $urandom_range(0, 1); wb_preg = 6'($urandom_range(0, 7)); wb_data = $urandom;
      ex_ready = $urandom_range(0, 9) < 6;
      flush    = $urandom_range(0, 99) < 3;
      if (n == 200) begin
        #2 rst = 1'b0;
        #1;
        chk("midrun reset ex_valid", ex_valid, 0);
        chk("midrun reset fire_ready", fire_ready, 1);
        chk("midrun reset ex_pc", ex_pc, 0);
        q.delete();
        for (int i = 0; i < 64; i++) mprf[i] = 0;
        @(negedge clk) rst = 1'b1;
      end
      cyc();
    end
    fire(0, 0, 0, 0, 0); wb_valid = 0; flush = 0; ex_ready = 1;
    for (int n = 0; n < 3; n++) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/reg_read_stage.md
# reg_read_stage

Register-read stage directly downstream of the scheduler. It accepts one fired instruction per cycle: destination and source physical registers, PC and immediate. It reads both source operands from an internal physical register file, with same-cycle writeback bypass, and presents a registered operand packet to the execute stage through a valid/ready handshake. A one-entry skid buffer absorbs execute backpressure, so `fire_ready` is a registered signal. Held operands keep capturing writebacks while they stall.

## Interface
- `NUM_PREGS`, 64: number of physical registers. `PREG_W = $clog2(NUM_PREGS)`.
- `XLEN`, 32: operand, PC and immediate width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (`rst`=0 resets immediately).
- `fire_valid`  in  1  scheduler presents an instruction.
- `fire_ready`  out  1  stage can accept; equals `!skid_valid`; registered.
- `fire_dst_preg`, `fire_src1_preg`, `fire_src2_preg`  in  `PREG_W`  fired pregs.
- `fire_pc`, `fire_imm`  in  `XLEN`  fired PC and immediate.
- `wb_valid`  in  1  writeback this cycle.
- `wb_preg`  in  `PREG_W`  writeback destination preg.
- `wb_data`  in  `XLEN`  writeback value.
- `flush`  in  1  discard all in-flight packets.
- `ex_valid`  out  1  output packet valid.
- `ex_ready`  in  1  execute stage accepts.
- `ex_dst_preg`  out  `PREG_W`  output destination preg.
- `ex_src1_preg`, `ex_src2_preg`  out  `PREG_W`  output source pregs.
- `ex_src1_val`, `ex_src2_val`  out  `XLEN`  output operand values.
- `ex_pc`, `ex_imm`  out  `XLEN`  output PC and immediate.

## Operation
- **PRF:** `NUM_PREGS` x `XLEN` entries, 2 combinational read ports, 1 write port.
  - Write on the rising edge when `wb_valid` is high and `wb_preg` != 0.
  - p0 always reads 0; writes to p0 are ignored.
- **Operand read:** for each source `s`:
  - value = 0 if `s` == 0;
  - else `wb_data` if `wb_valid` is high and `wb_preg` == `s`;
  - else PRF[`s`].
- **Accept:** `accept = fire_valid & fire_ready & !flush`.
- **Storage:** two slots, OUT (drives the `ex_*` outputs) and SKID. OUT is always older than SKID.
- **Stage update each edge:** let `out_free = !ex_valid | ex_ready`.
  - `flush`: OUT and SKID become invalid. This has priority over every other stage update.
  - `out_free` and SKID valid: OUT takes SKID; SKID becomes empty. `accept` cannot occur in this case, because `fire_ready` is 0.
  - `out_free` and SKID empty: OUT takes the accepted packet, or becomes invalid if nothing was accepted.
  - `!out_free`: OUT holds. On `accept`, SKID takes the packet.
- **Snoop:** every stored operand (OUT or SKID, whether holding or moving) whose preg is nonzero and equals `wb_preg` while `wb_valid` is high is replaced by `wb_data` at the edge.
- **Flush and PRF:** the PRF write still happens in a flush cycle.
- **Reset:**
  - `ex_valid`=0 and all `ex_*` payload outputs are 0.
  - SKID is empty, so `fire_ready`=1.
  - All PRF entries are 0.
  - Reset asserted mid-operation drops all packets immediately.

## Timing
- **Latency:** an instruction accepted at edge N appears on `ex_*` with `ex_valid`=1 after edge N, provided OUT is free. Otherwise it waits in SKID.
- **Throughput:** one packet per cycle while `ex_ready`=1.
- **`fire_ready`:** depends only on state; there is no combinational path from `ex_ready`. It falls in the cycle after a packet enters SKID and rises in the cycle after SKID drains into OUT.
- **`ex_*` stability:** payload is stable while `ex_valid`=1 and `ex_ready`=0, except for operand values updated by snoop.
- **Write/read same cycle:** a writeback and a read of the same preg in one cycle return the new value through the bypass.

## Test plan
- **Basic read:** write p5=0xDEADBEEF. Next cycle fire src1=5, src2=0, dst=10 -> one cycle later `ex_valid`=1, `ex_src1_val`=0xDEADBEEF, `ex_src2_val`=0, `ex_dst_preg`=10.
- **Same-cycle bypass:** `wb_preg`=7, `wb_data`=0x1234 in the same cycle as a fire with src1=7 -> `ex_src1_val`=0x1234. A later read of p7 also returns 0x1234.
- **Backpressure:**
  - Hold `ex_ready`=0 and fire A (pc 0x1000) then B (pc 0x2000) -> `fire_ready`=0 after B, and `ex_pc` holds 0x1000.
  - Then raise `ex_ready` -> `ex_pc` shows 0x1000 then 0x2000 on consecutive cycles, and `fire_ready` returns to 1.
- **Snoop while stalled:** A held in OUT with src2=9 (PRF value 0), B in SKID with src1=9. Write back p9=0xAA -> next cycle `ex_src2_val`=0xAA. After A drains, B shows `ex_src1_val`=0xAA.
- **p0 rule:** write back p0=0xFF, then fire src1=0 -> `ex_src1_val`=0.
- **Flush and reset:**
  - With OUT and SKID both full, assert `flush` together with `wb` p3=0x55 -> next cycle `ex_valid`=0 and `fire_ready`=1, and a later read of p3 returns 0x55.
  - Asserting `rst`=0 mid-stream -> `ex_valid`=0 immediately, without waiting for an edge.
